link_state_rx: RTL and testbench

- Receive side of the one-wire state link.
- The link line is pulled up and idles high. A sender changes its state by driving a frame onto the line:
  - a low start bit,
  - DATA_W data bits, LSB first,
  - release of the line, which gives a high stop bit.
- This block samples the shared line, decodes frames and presents the partner's state with a valid pulse.
- It sits beside the link driver on each board, and its output feeds the local state logic.

---
 rtl/link_pkg.sv | 7 +
 rtl/link_sync.sv | 24 ++
 rtl/link_state_rx.sv | 151 +++++++++++++++
 tb/tb_link_state_rx.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/link_pkg.sv
// Shared types and line levels for the one-wire state link.
package link_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, RECOVER} rx_state_t;
  localparam logic LINK_IDLE_LVL  = 1'b1;
  localparam logic LINK_START_LVL = 1'b0;
  localparam int   MAX_DATA_W     = 8;
endpackage

// File: rtl/link_sync.sv
// Two-flop synchronizer; flops reset to 1 so an idle (pulled-up) line never
// looks like a start bit coming out of reset.
module link_sync #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  logic [W-1:0] r_q1, r_q2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q1 <= '1;
      r_q2 <= '1;
    end else begin
      r_q1 <= i_d;
      r_q2 <= r_q1;
    end
  end

  assign o_q = r_q2;
endmodule

// File: rtl/link_state_rx.sv
// One-wire state link receiver: start bit, DATA_W bits LSB first, high stop.
// Define LINK_RX_SYNC_EN to sample the line through a 2-flop synchronizer.
module link_state_rx
  import link_pkg::*;
#(
  parameter int DATA_W       = 1,
  parameter int CLKS_PER_BIT = 1
) (
  input  logic              clk,
  input  logic              Locked_n,
  input  logic              rx_en,
  input  logic              data_link,
  output logic [DATA_W-1:0] partner_state,
  output logic              state_valid,
  output logic              state_changed,
  output logic              frame_err,
  output logic              busy
);
  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int TW   = $clog2(CLKS_PER_BIT + 1);
  localparam int BW   = $clog2(DATA_W + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_LAST = TW'((HALF == 0) ? 0 : HALF - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_W - 1);

  logic w_s;

`ifdef LINK_RX_SYNC_EN
  link_sync #(.W(1)) u_sync (
    .clk  (clk),
    .rst_n(Locked_n),
    .i_d  (data_link),
    .o_q  (w_s)
  );
`else
  assign w_s = data_link;
`endif

  rx_state_t         r_state, w_state;
  logic [TW-1:0]     r_tick, w_tick;
  logic [BW-1:0]     r_bit, w_bit;
  logic [DATA_W-1:0] r_shift, w_shift;
  logic [DATA_W-1:0] r_ps, w_ps;
  logic              r_valid, w_valid;
  logic              r_chg, w_chg;
  logic              r_err, w_err;
  logic              r_busy;

  always_comb begin
    w_state = r_state;
    w_tick  = r_tick;
    w_bit   = r_bit;
    w_shift = r_shift;
    w_ps    = r_ps;
    w_valid = 1'b0;
    w_chg   = 1'b0;
    w_err   = 1'b0;
    case (r_state)
      IDLE: begin
        // With HALF = 0 the start bit is already confirmed by this sample.
        if (rx_en && w_s == LINK_START_LVL) begin
          w_tick  = '0;
          w_bit   = '0;
          w_state = (HALF == 0) ? DATA : START;
        end
      end
      START: begin
        if (r_tick == HALF_LAST) begin
          w_tick  = '0;
          w_state = (w_s == LINK_START_LVL) ? DATA : IDLE;
        end else begin
          w_tick = r_tick + TW'(1);
        end
      end
      DATA: begin
        if (r_tick == TICK_LAST) begin
          w_tick  = '0;
          w_shift = (r_shift >> 1) | (DATA_W'(w_s) << (DATA_W - 1));
          if (r_bit == BIT_LAST) begin
            w_bit   = '0;
            w_state = STOP;
          end else begin
            w_bit = r_bit + BW'(1);
          end
        end else begin
          w_tick = r_tick + TW'(1);
        end
      end
      STOP: begin
        if (r_tick == TICK_LAST) begin
          w_tick = '0;
          if (w_s == LINK_IDLE_LVL) begin
            w_ps    = r_shift;
            w_valid = 1'b1;
            w_chg   = (r_shift != r_ps);
            w_state = IDLE;
          end else begin
            w_err   = 1'b1;
            w_state = RECOVER;
          end
        end else begin
          w_tick = r_tick + TW'(1);
        end
      end
      RECOVER: begin
        if (w_s == LINK_IDLE_LVL) w_state = IDLE;
      end
      default: w_state = IDLE;
    endcase
    // Losing the enable abandons any frame in flight silently.
    if (r_state != IDLE && !rx_en) begin
      w_state = IDLE;
      w_tick  = '0;
      w_bit   = '0;
      w_ps    = r_ps;
      w_valid = 1'b0;
      w_chg   = 1'b0;
      w_err   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge Locked_n) begin
    if (!Locked_n) begin
      r_state <= IDLE;
      r_tick  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_ps    <= '0;
      r_valid <= 1'b0;
      r_chg   <= 1'b0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_tick  <= w_tick;
      r_bit   <= w_bit;
      r_shift <= w_shift;
      r_ps    <= w_ps;
      r_valid <= w_valid;
      r_chg   <= w_chg;
      r_err   <= w_err;
      r_busy  <= (w_state != IDLE);
    end
  end

  assign partner_state = r_ps;
  assign state_valid   = r_valid;
  assign state_changed = r_chg;
  assign frame_err     = r_err;
  assign busy          = r_busy;
endmodule

// File: tb/tb_link_state_rx.sv
// Bench for link_state_rx: directed frames on two configurations plus a
// randomized frame stream predicted from the frame timing rules.
module tb_link_state_rx;
`ifdef LINK_RX_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif
  localparam int MAXN = 4096;
  localparam int NFR  = 20;

  logic clk = 1'b0;
  logic rst_n;
  logic en_a, ln_a, en_b, ln_b;
  logic [0:0] ps_a;
  logic [3:0] ps_b;
  logic v_a, c_a, e_a, b_a, v_b, c_b, e_b, b_b;
  int total = 0;
  int bad = 0;

  logic       wave [2][MAXN];
  bit         xv [2][MAXN];
  bit         xc [2][MAXN];
  bit         xe [2][MAXN];
  bit         xb [2][MAXN];
  logic [7:0] xp [2][MAXN];
  int         len [2];

  always #5 clk = ~clk;

  link_state_rx #(.DATA_W(1), .CLKS_PER_BIT(1)) u_a (
    .clk(clk), .Locked_n(rst_n), .rx_en(en_a), .data_link(ln_a),
    .partner_state(ps_a), .state_valid(v_a), .state_changed(c_a),
    .frame_err(e_a), .busy(b_a));

  link_state_rx #(.DATA_W(4), .CLKS_PER_BIT(4)) u_b (
    .clk(clk), .Locked_n(rst_n), .rx_en(en_b), .data_link(ln_b),
    .partner_state(ps_b), .state_valid(v_b), .state_changed(c_b),
    .frame_err(e_b), .busy(b_b));

  task automatic edge_ab(input logic la, input logic lb);
    ln_a = la;
    ln_b = lb;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Line level at offset j of a frame whose start bit begins at j = 0.
  function automatic logic frame_lvl(int j, int dw, int cpb, logic [7:0] v, logic stp);
    if (j < cpb) return 1'b0;
    if (j < (dw + 1) * cpb) return v[(j - cpb) / cpb];
    return stp;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({ps_a, v_a, c_a, e_a, b_a, ps_b, v_b, c_b, e_b, b_b} !== '0) begin
      bad++;
      $display("FAIL reset_in got a=%b%b%b%b%b b=%h%b%b%b%b exp all 0",
               ps_a, v_a, c_a, e_a, b_a, ps_b, v_b, c_b, e_b, b_b);
    end
    rst_n = 1'b1;
    repeat (4) edge_ab(1'b1, 1'b1);
    total++;
    if ({ps_a, v_a, c_a, e_a, b_a, ps_b, v_b, c_b, e_b, b_b} !== '0) begin
      bad++;
      $display("FAIL reset_idle got a=%b%b%b%b%b b=%h%b%b%b%b exp all 0",
               ps_a, v_a, c_a, e_a, b_a, ps_b, v_b, c_b, e_b, b_b);
    end
  endtask

  // DATA_W=1: frames 1, 1, 0 -> changed, unchanged, changed.
  task automatic test_basic();
    logic [2:0] dat = 3'b011;
    logic [2:0] chg = 3'b101;
    for (int f = 0; f < 3; f++) begin
      for (int j = 0; j < 6; j++) begin
        logic hit;
        edge_ab(frame_lvl(j, 1, 1, {7'd0, dat[f]}, 1'b1), 1'b1);
        hit = (j == 2 + LAT);
        total++;
        if ({v_a, c_a, e_a} !== {hit, hit & chg[f], 1'b0}) begin
          bad++;
          $display("FAIL basic_pulse f=%0d j=%0d got v/c/e=%b%b%b exp=%b%b0",
                   f, j, v_a, c_a, e_a, hit, hit & chg[f]);
        end
        if (hit) begin
          total++;
          if (ps_a !== dat[f]) begin
            bad++;
            $display("FAIL basic_value f=%0d got=%b exp=%b", f, ps_a, dat[f]);
          end
        end
      end
    end
  endtask

  task automatic test_wide();
    for (int j = 0; j < 26 + LAT; j++) begin
      logic hit;
      edge_ab(1'b1, frame_lvl(j, 4, 4, 8'h0A, 1'b1));
      hit = (j == 22 + LAT);
      total++;
      if ({v_b, c_b, e_b, b_b} !== {hit, hit, 1'b0, (j >= LAT && j < 22 + LAT)}) begin
        bad++;
        $display("FAIL wide_ctl j=%0d got v/c/e/busy=%b%b%b%b", j, v_b, c_b, e_b, b_b);
      end
    end
    total++;
    if (ps_b !== 4'hA) begin
      bad++;
      $display("FAIL wide_value got=%h exp=a", ps_b);
    end
  endtask

  task automatic test_glitch();
    for (int j = 0; j < 8; j++) begin
      edge_ab(1'b1, (j == 0) ? 1'b0 : 1'b1);
      total++;
      if ({v_b, e_b, b_b} !== {1'b0, 1'b0, (j >= LAT && j <= LAT + 1)}) begin
        bad++;
        $display("FAIL glitch j=%0d got v/e/busy=%b%b%b", j, v_b, e_b, b_b);
      end
    end
  endtask

  task automatic test_frame_err();
    for (int j = 0; j < 33 + LAT; j++) begin
      logic hit;
      edge_ab(1'b1, (j < 30) ? frame_lvl(j, 4, 4, 8'h03, 1'b0) : 1'b1);
      hit = (j == 22 + LAT);
      total++;
      if ({v_b, e_b, b_b, ps_b} !== {1'b0, hit, (j >= LAT && j < 30 + LAT), 4'hA}) begin
        bad++;
        $display("FAIL ferr j=%0d got v/e/busy=%b%b%b ps=%h exp e=%b ps=a",
                 j, v_b, e_b, b_b, ps_b, hit);
      end
    end
    for (int j = 0; j < 26 + LAT; j++) begin
      logic hit;
      edge_ab(1'b1, frame_lvl(j, 4, 4, 8'h05, 1'b1));
      hit = (j == 22 + LAT);
      if (hit) begin
        total++;
        if ({v_b, c_b, e_b, ps_b} !== {3'b110, 4'h5}) begin
          bad++;
          $display("FAIL ferr_next got v/c/e=%b%b%b ps=%h exp 110 ps=5", v_b, c_b, e_b, ps_b);
        end
      end
    end
  endtask

  task automatic test_abort();
    for (int j = 0; j < 40; j++) begin
      en_b = !(j >= 12 && j < 16);
      edge_ab(1'b1, (j < 12) ? frame_lvl(j, 4, 4, 8'h0F, 1'b1) : 1'b1);
      total++;
      if ({v_b, c_b, e_b, b_b, ps_b} !== {3'b000, (j >= LAT && j < 12), 4'h5}) begin
        bad++;
        $display("FAIL abort j=%0d got v/c/e/busy=%b%b%b%b ps=%h exp busy=%b ps=5",
                 j, v_b, c_b, e_b, b_b, ps_b, (j >= LAT && j < 12));
      end
    end
    en_b = 1'b1;
  endtask

  task automatic test_reset_mid();
    for (int j = 0; j < 10; j++) edge_ab(1'b1, frame_lvl(j, 4, 4, 8'h06, 1'b1));
    total++;
    if (b_b !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_busy_before got=%b exp=1", b_b);
    end
    ln_b = 1'b1;
    rst_n = 1'b0;
    #1;
    total++;
    if ({ps_b, v_b, c_b, e_b, b_b} !== '0) begin
      bad++;
      $display("FAIL rstmid_async got ps=%h v/c/e/busy=%b%b%b%b exp 0", ps_b, v_b, c_b, e_b, b_b);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int j = 0; j < 26 + LAT; j++) begin
      edge_ab(1'b1, frame_lvl(j, 4, 4, 8'h09, 1'b1));
      if (j == 22 + LAT) begin
        total++;
        if ({v_b, c_b, e_b, ps_b} !== {3'b110, 4'h9}) begin
          bad++;
          $display("FAIL rstmid_after got v/c/e=%b%b%b ps=%h exp 110 ps=9", v_b, c_b, e_b, ps_b);
        end
      end
    end
  endtask

  // Lay out NFR random frames (good or bad stop, 0..3 idle gap) and the
  // responses the frame timing rules predict for every edge.
  task automatic build(input int d, input int dw, input int cpb);
    int n, k, ev, r, hold, half;
    logic [7:0] v, prev, cur;
    bit good;
    half = cpb / 2;
    prev = '0;
    for (int i = 0; i < MAXN; i++) begin
      wave[d][i] = 1'b1; xv[d][i] = 0; xc[d][i] = 0; xe[d][i] = 0; xb[d][i] = 0; xp[d][i] = '0;
    end
    n = 3;
    for (int f = 0; f < NFR; f++) begin
      v = 8'($urandom) & 8'((1 << dw) - 1);
      good = ($urandom_range(0, 3) != 0);
      k = n;
      ev = k + half + (dw + 1) * cpb;
      for (int j = 0; j < cpb; j++) wave[d][k + j] = 1'b0;
      for (int i = 0; i < dw; i++)
        for (int c = 0; c < cpb; c++) wave[d][k + (i + 1) * cpb + c] = v[i];
      if (good) begin
        xv[d][ev + LAT] = 1;
        xc[d][ev + LAT] = (v != prev);
        xp[d][ev + LAT] = v;
        prev = v;
        for (int j = k + LAT; j < ev + LAT; j++) xb[d][j] = 1;
        n = ev + 1 + $urandom_range(0, 3);
      end else begin
        hold = $urandom_range(0, 8);
        for (int j = k + (dw + 1) * cpb; j <= ev + hold; j++) wave[d][j] = 1'b0;
        r = ev + hold + 1;
        xe[d][ev + LAT] = 1;
        for (int j = k + LAT; j < r + LAT; j++) xb[d][j] = 1;
        n = r + 1 + $urandom_range(0, 3);
      end
    end
    cur = '0;
    for (int i = 0; i < MAXN; i++) begin
      if (xv[d][i]) cur = xp[d][i];
      xp[d][i] = cur;
    end
    len[d] = n + LAT + 4;
  endtask

  task automatic test_random();
    int n;
    ln_a = 1'b1;
    ln_b = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    build(0, 1, 1);
    build(1, 4, 4);
    n = (len[0] > len[1]) ? len[0] : len[1];
    for (int i = 0; i < n; i++) begin
      edge_ab(wave[0][i], wave[1][i]);
      total++;
      if ({ps_a, v_a, c_a, e_a, b_a} !== {xp[0][i][0], xv[0][i], xc[0][i], xe[0][i], xb[0][i]}) begin
        bad++;
        $display("FAIL rand_a i=%0d got ps/v/c/e/busy=%b%b%b%b%b exp=%b%b%b%b%b", i,
                 ps_a, v_a, c_a, e_a, b_a, xp[0][i][0], xv[0][i], xc[0][i], xe[0][i], xb[0][i]);
      end
      total++;
      if ({ps_b, v_b, c_b, e_b, b_b} !== {xp[1][i][3:0], xv[1][i], xc[1][i], xe[1][i], xb[1][i]}) begin
        bad++;
        $display("FAIL rand_b i=%0d got ps=%h v/c/e/busy=%b%b%b%b exp ps=%h %b%b%b%b", i,
                 ps_b, v_b, c_b, e_b, b_b, xp[1][i][3:0], xv[1][i], xc[1][i], xe[1][i], xb[1][i]);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    en_a = 1'b1;
    en_b = 1'b1;
    ln_a = 1'b1;
    ln_b = 1'b1;
    test_reset();
    test_basic();
    test_wide();
    test_glitch();
    test_frame_err();
    test_abort();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
